// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state, request-kind and timeout defaults for mdr_mem_ctrl
package mem_ctrl_pkg;
  localparam int WAIT_MAX_DEF = 15;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RD_WAIT, S_RD_CAP, S_WR_WAIT, S_DONE} mem_ctrl_state_t;
  typedef enum logic {K_RD, K_WR} req_kind_t;
endpackage

// File: rtl/mdr_mem_ctrl_if.sv
// mdr_mem_ctrl_if: request/bus-load inputs, memory strobes, MDR controls and status; master drives requests, slave is the controller
interface mdr_mem_ctrl_if #(parameter int ADDR_W = 9);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic              bus_ld;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mdr_read;
  logic              mdr_en;
  logic              busy;
  logic              done;
  logic              err;
  modport master (output req_rd, req_wr, req_addr, bus_ld, mem_ready,
                  input  mem_addr, mem_rd, mem_wr, mdr_read, mdr_en, busy, done, err);
  modport slave  (input  req_rd, req_wr, req_addr, bus_ld, mem_ready,
                  output mem_addr, mem_rd, mem_wr, mdr_read, mdr_en, busy, done, err);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-cycle counter; ports clk, rst, i_clear, i_en, o_tc (high on the MAX-th counted cycle)
module mem_wait_timer #(parameter int MAX = 15) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = MAX > 1 ? $clog2(MAX) : 1;
  logic [W-1:0] r_cnt;
  assign o_tc = r_cnt == W'(MAX - 1);
  always_ff @(posedge clk)
    if (rst || i_clear) r_cnt <= '0;
    else if (i_en && !o_tc) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: MDR memory-side sequencer; ports clk, clr (sync active-high) and bus (mdr_mem_ctrl_if.slave); optional MEM_TIMEOUT_EN adds the ready-wait timeout
module mdr_mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W   = 9,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input logic           clk,
  input logic           clr,
  mdr_mem_ctrl_if.slave bus
);
  mem_ctrl_state_t   r_state;
  req_kind_t         r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              w_to;
`ifdef MEM_TIMEOUT_EN
  logic w_wait;
  logic w_tc;
  assign w_wait = r_state == S_RD_WAIT || r_state == S_WR_WAIT;
  mem_wait_timer #(.MAX(WAIT_MAX)) u_timer (
    .clk(clk), .rst(clr), .i_clear(!w_wait), .i_en(w_wait), .o_tc(w_tc)
  );
  assign w_to = w_wait && !bus.mem_ready && w_tc;
`else
  // no timeout without the timer; comparison keeps WAIT_MAX referenced
  assign w_to = WAIT_MAX < 0;
`endif
  always_ff @(posedge clk)
    if (clr) begin
      r_state <= S_IDLE;
      r_kind  <= K_RD;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else
      case (r_state)
        S_IDLE: if (bus.req_rd || bus.req_wr) begin
          r_state <= S_ADDR;
          r_kind  <= bus.req_rd ? K_RD : K_WR;
          r_addr  <= bus.req_addr;
          r_err   <= 1'b0;
        end
        S_ADDR:    r_state <= r_kind == K_RD ? S_RD_WAIT : S_WR_WAIT;
        S_RD_WAIT: if (bus.mem_ready) r_state <= S_RD_CAP;
                   else if (w_to) begin r_state <= S_DONE; r_err <= 1'b1; end
        S_WR_WAIT: if (bus.mem_ready) r_state <= S_DONE;
                   else if (w_to) begin r_state <= S_DONE; r_err <= 1'b1; end
        S_RD_CAP:  r_state <= S_DONE;
        default:   r_state <= S_IDLE;
      endcase
  assign bus.mem_addr = r_addr;
  assign bus.mem_rd   = r_state == S_RD_WAIT;
  assign bus.mem_wr   = r_state == S_WR_WAIT;
  assign bus.mdr_read = r_state == S_RD_CAP;
  // bus loads reach the MDR only while idle; the memory capture owns it otherwise
  assign bus.mdr_en   = r_state == S_RD_CAP || (r_state == S_IDLE && bus.bus_ld);
  assign bus.busy     = r_state != S_IDLE;
  assign bus.done     = r_state == S_DONE;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb_mdr_mem_ctrl: directed self-checking bench for mdr_mem_ctrl with a behavioural MDR
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end end
module tb_mdr_mem_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [31:0] mem_data = '0;
  logic [31:0] bus_data = '0;
  logic [31:0] mdr_q = '0;
  int checks = 0;
  int failures = 0;
  mdr_mem_ctrl_if #(.ADDR_W(9)) b ();
  mdr_mem_ctrl #(.ADDR_W(9), .WAIT_MAX(15)) dut (.clk(clk), .clr(clr), .bus(b));
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    if (b.mdr_en) mdr_q <= b.mdr_read ? mem_data : bus_data;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wc, dc, rc, en_cnt, bad_en;
    b.req_rd = 1'b1; b.req_wr = 1'b0; b.req_addr = 9'h1A5; b.bus_ld = 1'b0; b.mem_ready = 1'b1;
    mem_data = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      `CHK("rst_busy", b.busy, 1'b0)
      `CHK("rst_outs", {b.mem_rd, b.mem_wr, b.mdr_read, b.mdr_en, b.done, b.err}, 6'b0)
      `CHK("rst_addr", b.mem_addr, 9'h0)
    end
    clr = 1'b0;
    tick();
    `CHK("rd_addr", b.mem_addr, 9'h1A5)
    `CHK("rd_addr_busy", b.busy, 1'b1)
    `CHK("rd_addr_nostrobe", b.mem_rd, 1'b0)
    b.req_rd = 1'b0;
    tick();
    `CHK("rd_wait_strobe", b.mem_rd, 1'b1)
    `CHK("rd_wait_noen", b.mdr_en, 1'b0)
    tick();
    `CHK("rd_cap_sel_en", {b.mdr_read, b.mdr_en, b.mem_rd}, 3'b110)
    tick();
    `CHK("rd_done", b.done, 1'b1)
    `CHK("rd_mdr", mdr_q, 32'hDEADBEEF)
    tick();
    `CHK("rd_idle", {b.busy, b.done}, 2'b00)
    `CHK("rd_addr_hold", b.mem_addr, 9'h1A5)
    bus_data = 32'h12345678; b.bus_ld = 1'b1;
    #1;
    `CHK("bl_comb", {b.mdr_en, b.mdr_read}, 2'b10)
    tick();
    b.bus_ld = 1'b0;
    `CHK("bl_mdr", mdr_q, 32'h12345678)
    b.mem_ready = 1'b0; b.req_wr = 1'b1; b.req_addr = 9'h0F0;
    tick();
    b.req_wr = 1'b0;
    wc = 0; dc = 0;
    for (int i = 0; i < 8; i++) begin
      if (b.mem_wr) wc++;
      if (b.done) dc++;
      b.mem_ready = b.mem_wr && wc == 4;
      tick();
    end
    `CHK("wr_strobe_cycles", wc, 4)
    `CHK("wr_done_pulses", dc, 1)
    `CHK("wr_mdr_kept", mdr_q, 32'h12345678)
    `CHK("wr_addr", b.mem_addr, 9'h0F0)
    b.req_rd = 1'b1; b.req_wr = 1'b1; b.req_addr = 9'h055; b.bus_ld = 1'b1; b.mem_ready = 1'b1;
    bus_data = 32'hAAAA5555; mem_data = 32'hCAFEF00D;
    tick();
    b.req_rd = 1'b0; b.req_wr = 1'b0;
    `CHK("both_busld", mdr_q, 32'hAAAA5555)
    `CHK("both_addr", b.mem_addr, 9'h055)
    wc = 0; en_cnt = 0; bad_en = 0;
    for (int i = 0; i < 4; i++) begin
      if (b.mem_wr) wc++;
      if (b.mdr_en) en_cnt++;
      if (b.mdr_en && !b.mdr_read) bad_en++;
      tick();
    end
    b.bus_ld = 1'b0;
    `CHK("both_no_wr", wc, 0)
    `CHK("both_en_once", en_cnt, 1)
    `CHK("busy_busld_ignored", bad_en, 0)
    `CHK("both_mdr", mdr_q, 32'hCAFEF00D)
    `CHK("both_idle", b.busy, 1'b0)
    b.mem_ready = 1'b0; b.req_rd = 1'b1; b.req_addr = 9'h100;
    tick();
    b.req_rd = 1'b0;
    tick();
    `CHK("clr_pre_rd", b.mem_rd, 1'b1)
    clr = 1'b1;
    tick();
    clr = 1'b0;
    `CHK("clr_state", {b.busy, b.mem_rd, b.done}, 3'b000)
    `CHK("clr_addr", b.mem_addr, 9'h0)
    tick();
    `CHK("clr_no_done", {b.busy, b.done}, 2'b00)
    b.req_rd = 1'b1; b.req_addr = 9'h1FF;
    tick();
    b.req_rd = 1'b0;
    rc = 0; dc = 0;
    for (int i = 0; i < 100; i++) begin
      if (b.done) begin dc = 1; break; end
      if (b.mem_rd) rc++;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    `CHK("to_done", dc, 1)
    `CHK("to_wait_cycles", rc, 15)
    `CHK("to_err", b.err, 1'b1)
    `CHK("to_strobe_drop", b.mem_rd, 1'b0)
    tick();
    `CHK("to_mdr_kept", mdr_q, 32'hCAFEF00D)
    `CHK("to_err_hold", {b.busy, b.err}, 2'b01)
`else
    `CHK("nto_still_wait", dc, 0)
    `CHK("nto_strobe", {b.busy, b.mem_rd}, 2'b11)
    `CHK("nto_err", b.err, 1'b0)
    `CHK("nto_mdr_kept", mdr_q, 32'hCAFEF00D)
    clr = 1'b1;
    tick();
    clr = 1'b0;
`endif
    b.mem_ready = 1'b1; b.req_wr = 1'b1; b.req_addr = 9'h033;
    tick();
    b.req_wr = 1'b0;
    `CHK("accept_err_clr", b.err, 1'b0)
    tick();
    `CHK("wr0_strobe", b.mem_wr, 1'b1)
    b.req_rd = 1'b1; b.req_addr = 9'h044;
    tick();
    `CHK("wr0_done", b.done, 1'b1)
    tick();
    `CHK("b2b_not_in_done", {b.busy, b.mem_addr}, {1'b0, 9'h033})
    tick();
    b.req_rd = 1'b0;
    `CHK("b2b_accept", {b.busy, b.mem_addr}, {1'b1, 9'h044})
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
